// File: rtl/nibbler_io_pkg.sv
// rtl/nibbler_io_pkg.sv - shared types and widths for the Nibbler input conditioner
package nibbler_io_pkg;

    localparam int NIB_W = 4;

    // Gray-ordered so bit 1 alone is the debounced level.
    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b11,
        S_FALL = 2'b10
    } db_state_t;

endpackage

// File: rtl/btn_debounce_bit.sv
// rtl/btn_debounce_bit.sv - per-button 2-FF synchroniser plus debounce FSM with press pulse
module btn_debounce_bit
    import nibbler_io_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1_q, s2_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOW: begin
                if (s2_q) begin
                    state_d = S_RISE;
                    cnt_d   = CNT_ONE;
                end
            end
            S_RISE: begin
                if (!s2_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!s2_q) begin
                    state_d = S_FALL;
                    cnt_d   = CNT_ONE;
                end
            end
            S_FALL: begin
                if (s2_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulse is registered so it lines up with the level going high.
    always_comb begin
        press_d = (state_q == S_RISE) && s2_q && (cnt_q == CNT_LAST);
        level   = (state_q == S_HIGH) || (state_q == S_FALL);
        press   = press_q;
    end

endmodule

// File: rtl/nibbler_button_port.sv
// rtl/nibbler_button_port.sv - debounced pushbutton nibble for the Nibbler IN path
// NIBBLER_BTN_STICKY_EN builds the sticky press flags and overflow flag.
module nibbler_button_port
    import nibbler_io_pkg::*;
#(
    parameter int WIDTH     = NIB_W,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] data_out,
    output logic             btn_ovf
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        btn_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (btn_raw[i]),
            .level   (btn_level[i]),
            .press   (btn_press[i])
        );
    end

`ifdef NIBBLER_BTN_STICKY_EN
    logic [WIDTH-1:0] flag_q, flag_d;
    logic             ovf_q, ovf_d;

    // A press landing on the read cycle survives so the next IN still sees it.
    always_comb begin
        flag_d = (flag_q & ~{WIDTH{rd_ack}}) | btn_press;
        ovf_d  = ((|(btn_press & flag_q)) & ~rd_ack) | (ovf_q & ~rd_ack);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_out = flag_q;
    assign btn_ovf  = ovf_q;
`else
    logic unused_rd_ack;
    assign unused_rd_ack = rd_ack;
    assign data_out      = btn_level;
    assign btn_ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_nibbler_button_port.sv
// tb/tb_nibbler_button_port.sv - scoreboard bench for nibbler_button_port
module tb_nibbler_button_port;

`ifdef NIBBLER_BTN_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    localparam int SIG_LVL = 0, SIG_PRS = 1, SIG_DAT = 2, SIG_OVF = 3;
    localparam int SIG_DAT16 = 4, SIG_OVF16 = 5, SIG_LVL16 = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_raw = 4'h0;
    logic       rd_ack = 1'b0;
    logic [3:0] raw16 = 4'h0;
    logic       rd16 = 1'b0;

    logic [3:0] btn_level, btn_press, data_out;
    logic       btn_ovf;
    logic [3:0] level16, press16, data16;
    logic       ovf16;

    nibbler_button_port #(.DB_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .rd_ack    (rd_ack),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .data_out  (data_out),
        .btn_ovf   (btn_ovf)
    );

    nibbler_button_port dut16 (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (raw16),
        .rd_ack    (rd16),
        .btn_level (level16),
        .btn_press (press16),
        .data_out  (data16),
        .btn_ovf   (ovf16)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         sig;
        logic [3:0] val;
    } chk_t;

    chk_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string sig_name[7] = '{"level", "press", "data_out", "ovf", "data_out16", "ovf16", "level16"};

    function automatic logic [3:0] actual(int sig);
        case (sig)
            SIG_LVL:   return btn_level;
            SIG_PRS:   return btn_press;
            SIG_DAT:   return data_out;
            SIG_OVF:   return {3'b000, btn_ovf};
            SIG_DAT16: return data16;
            SIG_OVF16: return {3'b000, ovf16};
            default:   return level16;
        endcase
    endfunction

    task automatic expect_at(int c, int sig, logic [3:0] v);
        chk_t e;
        e.cyc = c;
        e.sig = sig;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (actual(sb[i].sig) !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got %h, expected %h",
                             sig_name[sb[i].sig], cyc, actual(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_%s cyc=%0d: never sampled, expected %h",
                         sig_name[sb[i].sig], sb[i].cyc, sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        int b;

        // Reset state
        step(2);
        for (int s = 0; s < 7; s++) expect_at(cyc, s, 4'h0);
        step(1);
        reset = 1'b0;
        step(2);

        // Clean press on bit 0, then release
        b = cyc;
        btn_raw = 4'h1;
        for (int k = 0; k < 10; k++) begin
            expect_at(b + 1 + k, SIG_PRS, (k == 5) ? 4'h1 : 4'h0);
            expect_at(b + 1 + k, SIG_LVL, (k >= 5) ? 4'h1 : 4'h0);
            expect_at(b + 1 + k, SIG_DAT, (k >= (STICKY ? 6 : 5)) ? 4'h1 : 4'h0);
        end
        step(10);
        b = cyc;
        btn_raw = 4'h0;
        for (int k = 0; k < 10; k++) begin
            expect_at(b + 1 + k, SIG_PRS, 4'h0);
            expect_at(b + 1 + k, SIG_LVL, (k >= 5) ? 4'h0 : 4'h1);
            expect_at(b + 1 + k, SIG_DAT, STICKY ? 4'h1 : ((k >= 5) ? 4'h0 : 4'h1));
        end
        step(10);
        b = cyc;
        rd_ack = 1'b1;
        expect_at(b, SIG_DAT, STICKY ? 4'h1 : 4'h0);
        expect_at(b + 1, SIG_DAT, 4'h0);
        expect_at(b, SIG_OVF, 4'h0);
        expect_at(b + 1, SIG_OVF, 4'h0);
        step(1);
        rd_ack = 1'b0;
        step(1);

        // Bounce on bit 2: two stable cycles at a time is rejected
        b = cyc;
        for (int k = 0; k < 15; k++) begin
            expect_at(b + 1 + k, SIG_PRS, 4'h0);
            expect_at(b + 1 + k, SIG_LVL, 4'h0);
            expect_at(b + 1 + k, SIG_DAT, 4'h0);
        end
        btn_raw = 4'h4; step(2);
        btn_raw = 4'h0; step(2);
        btn_raw = 4'h4; step(2);
        btn_raw = 4'h0; step(9);

        // Sticky read of a short press on bit 1
        b = cyc;
        btn_raw = 4'h2;
        for (int k = 0; k < 16; k++) begin
            expect_at(b + 1 + k, SIG_PRS, (k == 5) ? 4'h2 : 4'h0);
            expect_at(b + 1 + k, SIG_LVL, (k >= 5 && k <= 10) ? 4'h2 : 4'h0);
            expect_at(b + 1 + k, SIG_DAT, STICKY ? ((k >= 6) ? 4'h2 : 4'h0)
                                                 : ((k >= 5 && k <= 10) ? 4'h2 : 4'h0));
        end
        step(6);
        btn_raw = 4'h0;
        step(10);
        b = cyc;
        rd_ack = 1'b1;
        expect_at(b, SIG_DAT, STICKY ? 4'h2 : 4'h0);
        expect_at(b + 1, SIG_DAT, 4'h0);
        step(1);
        rd_ack = 1'b0;
        step(1);

        // Press on bit 3 coinciding with the read strobe
        b = cyc;
        btn_raw = 4'h8;
        for (int k = 0; k < 8; k++) expect_at(b + 1 + k, SIG_PRS, (k == 5) ? 4'h8 : 4'h0);
        step(6);
        rd_ack = 1'b1;
        expect_at(cyc, SIG_DAT, STICKY ? 4'h0 : 4'h8);
        expect_at(cyc + 1, SIG_DAT, 4'h8);
        expect_at(cyc + 1, SIG_OVF, 4'h0);
        step(1);
        rd_ack = 1'b0;
        btn_raw = 4'h0;
        step(8);

        // Second press on bit 3 without a read raises overflow
        b = cyc;
        btn_raw = 4'h8;
        for (int k = 0; k < 8; k++) expect_at(b + 1 + k, SIG_PRS, (k == 5) ? 4'h8 : 4'h0);
        expect_at(b + 6, SIG_OVF, 4'h0);
        for (int k = 6; k < 10; k++) expect_at(b + 1 + k, SIG_OVF, STICKY ? 4'h1 : 4'h0);
        expect_at(b + 7, SIG_DAT, 4'h8);
        step(10);
        rd_ack = 1'b1;
        expect_at(cyc, SIG_OVF, STICKY ? 4'h1 : 4'h0);
        expect_at(cyc + 1, SIG_OVF, 4'h0);
        expect_at(cyc + 1, SIG_DAT, STICKY ? 4'h0 : 4'h8);
        step(1);
        rd_ack = 1'b0;
        btn_raw = 4'h0;
        step(8);

        // Default DB_CYCLES=16 instance: latency and rd_ack behaviour
        b = cyc;
        raw16 = 4'h9;
        expect_at(b + 17, SIG_LVL16, 4'h0);
        expect_at(b + 17, SIG_DAT16, 4'h0);
        expect_at(b + 18, SIG_LVL16, 4'h9);
        expect_at(b + 18, SIG_DAT16, STICKY ? 4'h0 : 4'h9);
        expect_at(b + 19, SIG_DAT16, 4'h9);
        expect_at(b + 20, SIG_DAT16, 4'h9);
        expect_at(b + 21, SIG_DAT16, STICKY ? 4'h0 : 4'h9);
        expect_at(b + 22, SIG_DAT16, STICKY ? 4'h0 : 4'h9);
        for (int k = 16; k < 22; k++) expect_at(b + 1 + k, SIG_OVF16, 4'h0);
        step(20);
        rd16 = 1'b1;
        step(1);
        rd16 = 1'b0;
        step(3);

        // Reset with all buttons held, then debounce again
        btn_raw = 4'hF;
        step(8);
        reset = 1'b1;
        for (int s = 0; s < 7; s++) expect_at(cyc, s, 4'h0);
        step(2);
        reset = 1'b0;
        b = cyc;
        for (int k = 0; k < 8; k++) begin
            expect_at(b + 1 + k, SIG_PRS, (k == 5) ? 4'hF : 4'h0);
            expect_at(b + 1 + k, SIG_LVL, (k >= 5) ? 4'hF : 4'h0);
            expect_at(b + 1 + k, SIG_DAT, (k >= (STICKY ? 6 : 5)) ? 4'hF : 4'h0);
        end
        step(10);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
